// File: rtl/oled_pkg.sv
// OLED power sequencer shared types: step encoding and the constant
// init/shutdown step program.
package oled_pkg;

  typedef enum logic [1:0] {
    OP_CMD,
    OP_PIN,
    OP_DLY,
    OP_END
  } op_e;

  typedef enum logic [1:0] {
    PIN_VDD,
    PIN_VBAT,
    PIN_RES
  } pin_e;

  typedef struct packed {
    op_e        op;
    logic [7:0] arg;
  } step_t;

  localparam logic [4:0] INIT_PC  = 5'd0;
  localparam logic [4:0] SHUT_PC  = 5'd21;
  localparam logic [1:0] DLY_VDD  = 2'd0;
  localparam logic [1:0] DLY_RES  = 2'd1;
  localparam logic [1:0] DLY_VBAT = 2'd2;

  function automatic step_t cmd(input logic [7:0] b);
    return '{op: OP_CMD, arg: b};
  endfunction

  // PIN arg: [2:1] pin select, [0] pin level (pins are active-low)
  function automatic step_t pin(input pin_e sel, input logic lvl);
    return '{op: OP_PIN, arg: {5'd0, sel, lvl}};
  endfunction

  function automatic step_t dly(input logic [1:0] idx);
    return '{op: OP_DLY, arg: {6'd0, idx}};
  endfunction

  function automatic step_t rom(input logic [4:0] pc);
    case (pc)
      5'd0:    return pin(PIN_VDD, 1'b0);
      5'd1:    return dly(DLY_VDD);
      5'd2:    return cmd(8'hAE);
      5'd3:    return pin(PIN_RES, 1'b0);
      5'd4:    return dly(DLY_RES);
      5'd5:    return pin(PIN_RES, 1'b1);
      5'd6:    return dly(DLY_RES);
      5'd7:    return cmd(8'h8D);
      5'd8:    return cmd(8'h14);
      5'd9:    return cmd(8'hD9);
      5'd10:   return cmd(8'hF1);
      5'd11:   return pin(PIN_VBAT, 1'b0);
      5'd12:   return dly(DLY_VBAT);
      5'd13:   return cmd(8'h81);
      5'd14:   return cmd(8'h0F);
      5'd15:   return cmd(8'hA0);
      5'd16:   return cmd(8'hC0);
      5'd17:   return cmd(8'hDA);
      5'd18:   return cmd(8'h00);
      5'd19:   return cmd(8'hAF);
      5'd21:   return cmd(8'hAE);
      5'd22:   return pin(PIN_VBAT, 1'b1);
      5'd23:   return dly(DLY_VBAT);
      5'd24:   return pin(PIN_VDD, 1'b1);
      default: return '{op: OP_END, arg: 8'h00};
    endcase
  endfunction

endpackage

// File: rtl/oled_power_sequencer.sv
// OLED panel power-up/power-down sequencer: steps the constant program,
// driving supply/reset pins, SPI command bytes and the delay timer.
module oled_power_sequencer
  import oled_pkg::*;
#(
  parameter int unsigned T_VDD  = 100_000,
  parameter int unsigned T_RES  = 100_000,
  parameter int unsigned T_VBAT = 10_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  output logic        busy,
  output logic        on,
  output logic        oled_vdd_n,
  output logic        oled_vbat_n,
  output logic        oled_res_n,
  output logic        oled_dc,
  output logic [7:0]  spi_data,
  output logic        spi_valid,
  input  logic        spi_ready,
  input  logic        spi_idle,
  output logic        tmr_clr,
  output logic [31:0] tmr_n,
  input  logic        tmr_t
);

  typedef enum logic [2:0] {
    S_OFF,
    S_FETCH,
    S_SEND,
    S_DRAIN,
    S_PINSET,
    S_TCLR,
    S_TWAIT,
    S_ON
  } state_e;

  state_e      state, state_d;
  logic [4:0]  pc, pc_d;
  logic        busy_d, on_d;
  logic        vdd_d, vbat_d, res_d;
  logic [7:0]  data_d;
  logic        valid_d, clr_d;
  logic [31:0] n_d;
  step_t       cur;

  assign cur     = rom(pc);
  assign oled_dc = 1'b0;

  function automatic logic [31:0] dly_cycles(input logic [1:0] idx);
    unique case (1'b1)
      idx == DLY_VDD: return 32'(T_VDD);
      idx == DLY_RES: return 32'(T_RES);
      default:        return 32'(T_VBAT);
    endcase
  endfunction

  always_comb begin
    state_d = state;
    pc_d    = pc;
    busy_d  = busy;
    on_d    = on;
    vdd_d   = oled_vdd_n;
    vbat_d  = oled_vbat_n;
    res_d   = oled_res_n;
    data_d  = spi_data;
    valid_d = spi_valid;
    clr_d   = 1'b1;
    n_d     = tmr_n;
    unique case (state)
      S_OFF: begin
        if (start) begin
          pc_d    = INIT_PC;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_ON: begin
        if (stop) begin
          pc_d    = SHUT_PC;
          on_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        unique case (cur.op)
          OP_CMD: begin
            valid_d = 1'b1;
            data_d  = cur.arg;
            state_d = S_SEND;
          end
          OP_PIN, OP_DLY: state_d = S_DRAIN;
          default: begin
            busy_d  = 1'b0;
            // init program ends below SHUT_PC, shutdown at/above it
            if (pc < SHUT_PC) begin
              on_d    = 1'b1;
              state_d = S_ON;
            end else begin
              state_d = S_OFF;
            end
          end
        endcase
      end
      S_SEND: begin
        if (spi_ready) begin
          valid_d = 1'b0;
          pc_d    = pc + 5'd1;
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (spi_idle) begin
          if (cur.op == OP_PIN) begin
            state_d = S_PINSET;
          end else begin
            n_d     = dly_cycles(cur.arg[1:0]);
            state_d = S_TCLR;
          end
        end
      end
      S_PINSET: begin
        unique case (1'b1)
          cur.arg[2:1] == PIN_VDD:  vdd_d  = cur.arg[0];
          cur.arg[2:1] == PIN_VBAT: vbat_d = cur.arg[0];
          default:                  res_d  = cur.arg[0];
        endcase
        pc_d    = pc + 5'd1;
        state_d = S_FETCH;
      end
      S_TCLR: begin
        clr_d   = 1'b0;
        state_d = S_TWAIT;
      end
      S_TWAIT: begin
        clr_d = 1'b0;
        if (tmr_t) begin
          clr_d   = 1'b1;
          pc_d    = pc + 5'd1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_OFF;
      pc          <= INIT_PC;
      busy        <= 1'b0;
      on          <= 1'b0;
      oled_vdd_n  <= 1'b1;
      oled_vbat_n <= 1'b1;
      oled_res_n  <= 1'b1;
      spi_data    <= 8'h00;
      spi_valid   <= 1'b0;
      tmr_clr     <= 1'b1;
      tmr_n       <= 32'd0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      busy        <= busy_d;
      on          <= on_d;
      oled_vdd_n  <= vdd_d;
      oled_vbat_n <= vbat_d;
      oled_res_n  <= res_d;
      spi_data    <= data_d;
      spi_valid   <= valid_d;
      tmr_clr     <= clr_d;
      tmr_n       <= n_d;
    end
  end

endmodule

// File: tb/tb_oled_power_sequencer.sv
// Scoreboard bench for oled_power_sequencer with SPI master and delay
// timer models.
module tb_oled_power_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop;
  logic        busy, on;
  logic        oled_vdd_n, oled_vbat_n, oled_res_n, oled_dc;
  logic [7:0]  spi_data;
  logic        spi_valid, spi_ready;
  logic        spi_idle;
  logic        tmr_clr;
  logic [31:0] tmr_n;
  logic        tmr_t;

  logic        stall, force_t;
  int          sh_cnt;
  logic        t_reg;
  logic [31:0] cnt;

  int checks = 0;
  int failures = 0;
  int bytes_seen = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] dly_q[$];

  always #5 clk = ~clk;

  oled_power_sequencer #(
    .T_VDD (4),
    .T_RES (3),
    .T_VBAT(10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .busy       (busy),
    .on         (on),
    .oled_vdd_n (oled_vdd_n),
    .oled_vbat_n(oled_vbat_n),
    .oled_res_n (oled_res_n),
    .oled_dc    (oled_dc),
    .spi_data   (spi_data),
    .spi_valid  (spi_valid),
    .spi_ready  (spi_ready),
    .spi_idle   (spi_idle),
    .tmr_clr    (tmr_clr),
    .tmr_n      (tmr_n),
    .tmr_t      (tmr_t)
  );

  // SPI master: ready one cycle after valid, shifter busy 8 cycles
  assign spi_idle = (sh_cnt == 0);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_ready <= 1'b0;
      sh_cnt    <= 0;
    end else if (spi_valid && spi_ready) begin
      spi_ready <= 1'b0;
      sh_cnt    <= 8;
    end else begin
      spi_ready <= spi_valid && !stall;
      if (sh_cnt > 0) sh_cnt <= sh_cnt - 1;
    end
  end

  // delay timer: tmr_t rises after tmr_n non-clear cycles
  assign tmr_t = t_reg | (force_t & tmr_clr);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_reg <= 1'b0;
      cnt   <= 32'd0;
    end else if (tmr_clr) begin
      t_reg <= 1'b0;
      cnt   <= 32'd0;
    end else if (!t_reg) begin
      cnt   <= cnt + 32'd1;
      t_reg <= (cnt + 32'd1 >= tmr_n);
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  localparam int W_VBAT = 0;
  localparam int W_CLR  = 1;
  localparam int W_ON   = 2;
  localparam int W_BUSY = 3;
  localparam int W_VLD  = 4;
  localparam int W_VDD  = 5;

  function automatic logic sig(input int sel);
    case (sel)
      W_VBAT:  return oled_vbat_n;
      W_CLR:   return tmr_clr;
      W_ON:    return on;
      W_BUSY:  return busy;
      W_VLD:   return spi_valid;
      default: return oled_vdd_n;
    endcase
  endfunction

  task automatic wait_cond(input int sel, input logic val,
                           input int limit, input string name);
    int i = 0;
    while (sig(sel) !== val && i < limit) begin
      @(negedge clk);
      i++;
    end
    chk(name, {31'd0, sig(sel)}, {31'd0, val});
  endtask

  // monitor
  logic       p_valid, p_ready, p_clr, p_t, p_vbat, p_res;
  logic [7:0] p_data;
  int         wait_len, cur_n, res_low;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_valid = 0; p_ready = 0; p_clr = 1; p_t = 0;
      p_vbat = 1; p_res = 1; p_data = 0;
      wait_len = 0; res_low = 0;
    end else begin
      if (spi_valid && spi_ready) begin
        bytes_seen++;
        if (exp_q.size() == 0)
          chk("spi_byte_unexpected", {24'd0, spi_data}, 32'hFFFF_FFFF);
        else
          chk("spi_byte", {24'd0, spi_data}, {24'd0, exp_q.pop_front()});
      end
      if (p_valid && !p_ready) begin
        chk("valid_hold", {31'd0, spi_valid}, 32'd1);
        chk("data_hold", {24'd0, spi_data}, {24'd0, p_data});
      end
      if (!tmr_clr) chk("no_valid_in_wait", {31'd0, spi_valid}, 32'd0);
      if (!p_clr) chk("advance_on_t", {31'd0, tmr_clr}, {31'd0, p_t});
      if (p_clr && !tmr_clr) begin
        wait_len = 1;
        if (dly_q.size() == 0) begin
          chk("dly_unexpected", tmr_n, 32'hFFFF_FFFF);
          cur_n = 0;
        end else begin
          cur_n = int'(dly_q.pop_front());
          chk("dly_n", tmr_n, 32'(cur_n));
        end
      end else if (!p_clr && !tmr_clr) begin
        wait_len++;
      end else if (!p_clr && tmr_clr) begin
        chk("wait_len", 32'(wait_len), 32'(cur_n + 1));
      end
      if (p_vbat && !oled_vbat_n)
        chk("idle_before_vbat", {31'd0, spi_idle}, 32'd1);
      if (!oled_res_n) begin
        res_low++;
      end else begin
        if (!p_res) chk("res_low_len", {31'd0, res_low >= 4}, 32'd1);
        res_low = 0;
      end
      p_valid = spi_valid; p_ready = spi_ready; p_data = spi_data;
      p_clr = tmr_clr; p_t = tmr_t;
      p_vbat = oled_vbat_n; p_res = oled_res_n;
    end
  end

  task automatic pulse(input logic s, input logic p);
    start = s;
    stop  = p;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  logic [7:0] init_bytes[12] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1,
    8'h81, 8'h0F, 8'hA0, 8'hC0, 8'hDA, 8'h00, 8'hAF};
  int n0, gap;

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    stall = 1'b0; force_t = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_vdd_n", {31'd0, oled_vdd_n}, 32'd1);
    chk("rst_vbat_n", {31'd0, oled_vbat_n}, 32'd1);
    chk("rst_res_n", {31'd0, oled_res_n}, 32'd1);
    chk("rst_dc", {31'd0, oled_dc}, 32'd0);
    chk("rst_valid", {31'd0, spi_valid}, 32'd0);
    chk("rst_data", {24'd0, spi_data}, 32'd0);
    chk("rst_tmr_clr", {31'd0, tmr_clr}, 32'd1);
    chk("rst_tmr_n", tmr_n, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_on", {31'd0, on}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // partial init, aborted by reset during the VBAT settle
    for (int i = 0; i < 5; i++) exp_q.push_back(init_bytes[i]);
    dly_q = '{32'd4, 32'd3, 32'd3, 32'd10};
    pulse(1'b1, 1'b0);
    wait_cond(W_VBAT, 1'b0, 400, "vbat_on_run1");
    wait_cond(W_CLR, 1'b0, 50, "twait_vbat_run1");
    repeat (3) @(negedge clk);
    chk("twait_tmr_n_vbat", tmr_n, 32'd10);
    chk("bytes_before_reset", 32'(exp_q.size()), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_vdd_n", {31'd0, oled_vdd_n}, 32'd1);
    chk("abort_vbat_n", {31'd0, oled_vbat_n}, 32'd1);
    chk("abort_res_n", {31'd0, oled_res_n}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    dly_q.delete();
    rst_n = 1'b1;
    @(negedge clk);

    n0 = bytes_seen;
    pulse(1'b0, 1'b1);
    repeat (10) @(negedge clk);
    chk("stop_in_off_busy", {31'd0, busy}, 32'd0);
    chk("stop_in_off_bytes", 32'(bytes_seen - n0), 32'd0);

    // full init from pc 0, timer forced high outside TWAIT
    force_t = 1'b1;
    foreach (init_bytes[i]) exp_q.push_back(init_bytes[i]);
    dly_q = '{32'd4, 32'd3, 32'd3, 32'd10};
    n0 = bytes_seen;
    pulse(1'b1, 1'b0);
    repeat (30) @(negedge clk);
    pulse(1'b1, 1'b0);
    wait_cond(W_ON, 1'b1, 800, "init_on");
    repeat (5) @(negedge clk);
    chk("init_busy", {31'd0, busy}, 32'd0);
    chk("init_on_held", {31'd0, on}, 32'd1);
    chk("init_byte_count", 32'(bytes_seen - n0), 32'd12);
    chk("init_q_empty", 32'(exp_q.size()), 32'd0);
    chk("init_vdd_n", {31'd0, oled_vdd_n}, 32'd0);
    chk("init_vbat_n", {31'd0, oled_vbat_n}, 32'd0);
    chk("init_res_n", {31'd0, oled_res_n}, 32'd1);
    chk("init_dc", {31'd0, oled_dc}, 32'd0);

    // shutdown via start&&stop, with SPI ready stalled 20 cycles
    force_t = 1'b0;
    stall = 1'b1;
    exp_q.push_back(8'hAE);
    dly_q.push_back(32'd10);
    n0 = bytes_seen;
    pulse(1'b1, 1'b1);
    wait_cond(W_VLD, 1'b1, 20, "shut_valid");
    repeat (20) @(negedge clk);
    stall = 1'b0;
    wait_cond(W_VBAT, 1'b1, 200, "shut_vbat_off");
    gap = 0;
    while (!oled_vdd_n && gap < 500) begin
      @(negedge clk);
      gap++;
    end
    chk("vbat_to_vdd_gap", {31'd0, gap >= 11}, 32'd1);
    chk("shut_vdd_n", {31'd0, oled_vdd_n}, 32'd1);
    wait_cond(W_BUSY, 1'b0, 100, "shut_busy_done");
    repeat (3) @(negedge clk);
    chk("shut_on", {31'd0, on}, 32'd0);
    chk("shut_busy", {31'd0, busy}, 32'd0);
    chk("shut_byte_count", 32'(bytes_seen - n0), 32'd1);
    chk("shut_dly_q_empty", 32'(dly_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
